// File: rtl/intq_pkg.sv
// Shared constants and helpers for the interrupt queue and its round-robin arbiter.
package intq_pkg;

    localparam int INTQ_NUM_CH = 4;
    localparam int INTQ_DEPTH  = 8;
    localparam int INTQ_DATA_W = 32;

    localparam logic [INTQ_DATA_W-1:0] INTQ_NOP = '0;

    // Index width that stays legal (>= 1 bit) even for a single channel.
    function automatic int intq_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requesting channel found searching
// upward from ptr with wrap-around; one-hot grant plus encoded index.
module rr_arbiter
    import intq_pkg::*;
#(
    parameter  int NUM_CH = INTQ_NUM_CH,
    localparam int IDX_W  = intq_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  idx
);

    int               sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // NOTE: every variable driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = 0;
        cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_CH) sum = sum - NUM_CH;
            cand = IDX_W'(sum);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/interrupt_queue.sv
// Round-robin arbitrated interrupt instruction FIFO with a synchronised reset release.
// Optional macro INTERRUPT_QUEUE_HIGHWATER_EN adds the high_water occupancy tracker.
module interrupt_queue
    import intq_pkg::*;
#(
    parameter int NUM_CH = INTQ_NUM_CH,
    parameter int DEPTH  = INTQ_DEPTH,
    parameter int DATA_W = INTQ_DATA_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_instr,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic [DATA_W-1:0]        interrupt_instruction,
    output logic                     int_valid,
    input  logic                     int_ack,
    output logic [$clog2(DEPTH):0]   count
`ifdef INTERRUPT_QUEUE_HIGHWATER_EN
    ,
    output logic [$clog2(DEPTH):0]   high_water
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = intq_idx_w(NUM_CH);

    // Reset asserts immediately but releases two edges later.
    logic [1:0] rst_sync_q;
    logic       rst_sync_n;

    // NOTE: sequential state is always updated with non-blocking assignments.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_sync_n = rst_sync_q[1];

    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [NUM_CH-1:0] arb_gnt;
    logic [PW-1:0]     arb_idx;
    logic              full, push, pop;
    logic [DATA_W-1:0] push_data;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req (ch_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // A pop in the same cycle does not free a slot for the push.
    assign full      = (count_q == CW'(DEPTH));
    assign ch_ready  = (rst_sync_n && !full) ? arb_gnt : '0;
    assign push      = |(ch_valid & ch_ready);
    assign int_valid = (count_q != '0);
    assign pop       = int_ack && int_valid;

    always_comb begin
        push_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arb_gnt[i]) push_data = ch_instr[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            rr_ptr_d = (arb_idx == PW'(NUM_CH - 1)) ? '0 : arb_idx + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // NOTE: storage has no reset; occupancy and the output mask keep stale words invisible.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign interrupt_instruction = int_valid ? mem[rd_ptr_q] : DATA_W'(INTQ_NOP);
    assign count                 = count_q;

`ifdef INTERRUPT_QUEUE_HIGHWATER_EN
    logic [CW-1:0] hw_q;

    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n)         hw_q <= '0;
        else if (count_q > hw_q) hw_q <= count_q;
    end

    assign high_water = hw_q;
`endif

endmodule
